// File: rtl/golden_response_checker.sv
// golden_response_checker
// Sweeps a stimulus index N over every pattern 0..2**WIDTH-1 and holds each
// pattern for SETTLE+1 cycles. On the last cycle of each pattern it samples
// the DUT's single-bit response and compares it with a copy of the golden
// vector that was latched when the sweep started.
//
// Ports:
//   CK           - clock; all state updates on the rising edge
//   reset        - asynchronous, active-low reset
//   start        - begins a sweep when sampled high in IDLE or DONE
//   abort        - ends a sweep in progress; partial results are kept
//   golden       - expected responses; bit i is the expected response to pattern i
//   N            - stimulus pattern index driven to the DUT
//   dut_out      - DUT response to the pattern currently on N
//   busy         - high while a sweep is in progress
//   done         - level, high in DONE
//   pass         - done with no mismatches
//   resp_vec     - captured responses; bit i is the response to pattern i
//   mismatch_cnt - number of mismatching patterns
//   first_fail   - lowest mismatching index; valid when mismatch_cnt != 0
module golden_response_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2**WIDTH-1:0]   golden,
    output logic [WIDTH-1:0]      N,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2**WIDTH-1:0]   resp_vec,
    output logic [WIDTH:0]        mismatch_cnt,
    output logic [WIDTH-1:0]      first_fail
);

    localparam int unsigned      NPAT        = 2**WIDTH;
    localparam logic [WIDTH-1:0] LAST_PAT    = WIDTH'(NPAT - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [WIDTH:0]   CNT_MAX     = (WIDTH+1)'(NPAT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic [NPAT-1:0]     golden_q;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            N            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            resp_vec     <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            wait_cnt     <= '0;
            golden_q     <= '0;
        end else if (abort && (state == WAIT || state == SAMPLE)) begin
            // Abort outranks start while busy; partial results stay visible.
            state    <= IDLE;
            busy     <= 1'b0;
            N        <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        golden_q     <= golden;
                        resp_vec     <= '0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        N            <= '0;
                        wait_cnt     <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    resp_vec[N] <= dut_out;
                    if (dut_out != golden_q[N]) begin
                        if (mismatch_cnt != CNT_MAX) begin
                            mismatch_cnt <= mismatch_cnt + (WIDTH+1)'(1);
                        end
                        if (mismatch_cnt == '0) begin
                            first_fail <= N;
                        end
                    end
                    if (N != LAST_PAT) begin
                        N        <= N + WIDTH'(1);
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_golden_response_checker.sv
// Directed bench for golden_response_checker: a default instance (WIDTH=4,
// SETTLE=1) driven by a behavioural AND/XOR DUT model, plus a SETTLE=3
// instance used for the longer-latency sweep.
module tb_golden_response_checker;

    logic        CK;
    logic        reset;
    logic        start, abort;
    logic [15:0] golden;
    logic [3:0]  N;
    logic        dut_out;
    logic        busy, done, pass;
    logic [15:0] resp_vec;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        xor_mode;

    logic        start3, abort3;
    logic [15:0] golden3;
    logic [3:0]  N3;
    logic        dut_out3;
    logic        busy3, done3, pass3;
    logic [15:0] resp_vec3;
    logic [4:0]  mismatch_cnt3;
    logic [3:0]  first_fail3;

    int vectors = 0;
    int miscompares = 0;
    int lat;

    golden_response_checker #(.WIDTH(4), .SETTLE(1)) u_dut (
        .CK(CK), .reset(reset), .start(start), .abort(abort),
        .golden(golden), .N(N), .dut_out(dut_out), .busy(busy),
        .done(done), .pass(pass), .resp_vec(resp_vec),
        .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
    );

    golden_response_checker #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .CK(CK), .reset(reset), .start(start3), .abort(abort3),
        .golden(golden3), .N(N3), .dut_out(dut_out3), .busy(busy3),
        .done(done3), .pass(pass3), .resp_vec(resp_vec3),
        .mismatch_cnt(mismatch_cnt3), .first_fail(first_fail3)
    );

    // Device under test models: 4-input AND, or XOR of all bits.
    always_comb dut_out  = xor_mode ? (^N) : (&N);
    always_comb dut_out3 = &N3;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles from the start edge until done; optionally checks that N
    // holds each pattern for two cycles in ascending order.
    task automatic wait_done(input bit chk_n, output int cycles);
        cycles = 0;
        while (!done && cycles < 200) begin
            if (chk_n) check("N_step", 32'(N), 32'(cycles / 2));
            tick();
            cycles++;
        end
    endtask

    task automatic wait_n(input logic [3:0] k);
        int c = 0;
        while (N !== k && c < 100) begin
            tick();
            c++;
        end
        check("wait_N", 32'(N), 32'(k));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_N"},    32'(N), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_resp"}, 32'(resp_vec), 0);
        check({tag, "_mcnt"}, 32'(mismatch_cnt), 0);
        check({tag, "_ff"},   32'(first_fail), 0);
    endtask

    initial begin
        reset = 1'b1; start = 0; abort = 0; golden = '0; xor_mode = 0;
        start3 = 0; abort3 = 0; golden3 = '0;
        #1 reset = 1'b0;
        #1 check_all_zero("reset");
        tick(); tick();
        reset = 1'b1;
        tick();

        // Matching AND DUT
        golden = 16'h8000;
        pulse_start();
        check("start_busy", 32'(busy), 1);
        wait_done(1'b1, lat);
        check("lat_and", 32'(lat), 32);
        check("and_done", 32'(done), 1);
        check("and_resp", 32'(resp_vec), 32'h8000);
        check("and_mcnt", 32'(mismatch_cnt), 0);
        check("and_pass", 32'(pass), 1);
        check("and_busy", 32'(busy), 0);
        check("and_Nheld", 32'(N), 15);

        // Single injected fault
        golden = 16'h8020;
        pulse_start();
        wait_done(1'b0, lat);
        check("f1_mcnt", 32'(mismatch_cnt), 1);
        check("f1_ff", 32'(first_fail), 5);
        check("f1_pass", 32'(pass), 0);
        check("f1_resp", 32'(resp_vec), 32'h8000);

        // Multiple faults: XOR DUT against all-zero golden
        xor_mode = 1'b1;
        golden = 16'h0000;
        pulse_start();
        wait_done(1'b0, lat);
        check("xor_lat", 32'(lat), 32);
        check("xor_mcnt", 32'(mismatch_cnt), 8);
        check("xor_ff", 32'(first_fail), 1);
        check("xor_resp", 32'(resp_vec), 32'h6996);

        // Start ignored while busy, golden changes ignored, abort at N=6
        pulse_start();
        wait_n(4'd3);
        pulse_start();
        check("restart_ign_N", 32'(N), 3);
        check("restart_ign_busy", 32'(busy), 1);
        golden = 16'hFFFF;
        wait_n(4'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_pass", 32'(pass), 0);
        check("abort_N", 32'(N), 0);
        check("abort_mcnt", 32'(mismatch_cnt), 3);
        check("abort_ff", 32'(first_fail), 1);
        check("abort_resp", 32'(resp_vec), 32'h0016);

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_mcnt", 32'(mismatch_cnt), 3);

        // start+abort in IDLE: start wins; golden toggled mid-sweep
        golden = 16'h0000;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_idle_busy", 32'(busy), 1);
        check("sa_idle_N", 32'(N), 0);
        check("sa_idle_mcnt", 32'(mismatch_cnt), 0);
        wait_n(4'd4);
        golden = 16'hFFFF;
        wait_done(1'b0, lat);
        check("gstab_mcnt", 32'(mismatch_cnt), 8);
        check("gstab_ff", 32'(first_fail), 1);
        check("gstab_resp", 32'(resp_vec), 32'h6996);

        // Async reset mid-sweep, between edges
        xor_mode = 1'b0;
        golden = 16'hFFFF;
        pulse_start();
        wait_n(4'd9);
        check("pre_reset_mcnt", 32'(mismatch_cnt), 9);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        tick();
        reset = 1'b1;
        tick();
        golden = 16'h8000;
        pulse_start();
        wait_done(1'b0, lat);
        check("post_reset_lat", 32'(lat), 32);
        check("post_reset_resp", 32'(resp_vec), 32'h8000);
        check("post_reset_pass", 32'(pass), 1);

        // Restart from DONE
        pulse_start();
        check("restart_done", 32'(done), 0);
        check("restart_busy", 32'(busy), 1);
        wait_done(1'b0, lat);
        check("restart_lat", 32'(lat), 32);
        check("restart_resp", 32'(resp_vec), 32'h8000);
        check("restart_mcnt", 32'(mismatch_cnt), 0);
        check("restart_pass", 32'(pass), 1);

        // start+abort while busy: abort wins
        pulse_start();
        tick(); tick(); tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy_busy", 32'(busy), 0);
        check("sa_busy_N", 32'(N), 0);
        check("sa_busy_done", 32'(done), 0);

        // SETTLE=3 instance
        golden3 = 16'h8000;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 300) begin
            tick();
            lat++;
        end
        check("s3_lat", 32'(lat), 64);
        check("s3_resp", 32'(resp_vec3), 32'h8000);
        check("s3_pass", 32'(pass3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
